// File: rtl/mac_grp_tx_time_stamp.sv
// -----------------------------------------------------------------------------
// mac_grp_tx_time_stamp
//
// Egress PTP time stamper. Watches the GMII-style transmit byte stream heading
// to the PHY, samples the free-running time counter on the SFD byte of every
// frame and, when the frame proves to be a PTP event message (EtherType
// PTP_ETHERTYPE, messageType < 4), publishes the SFD time together with
// messageType and sequenceId on a valid/ack record interface.
//
// Optional build macro: PTP_TX_VLAN_TAG_EN
//   defined   - a single 0x8100 VLAN tag after the MAC addresses is skipped;
//               all header offsets move by 4 bytes (SFD-to-valid latency 51).
//   undefined - 0x8100 frames are treated as non-PTP.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   tx_data      transmit byte, meaningful while tx_en=1
//   tx_en        frame-active qualifier (covers preamble too)
//   counter_val  free-running time counter
//   ts_time_hi   captured counter_val[63:32]
//   ts_time_lo   captured counter_val[31:0]
//   ts_msg_type  PTP messageType nibble
//   ts_seq_id    PTP sequenceId (big-endian as on the wire)
//   ts_valid     record available, held until accepted
//   ts_ack       consumer accepts the record when ts_valid && ts_ack
//   ts_drop      one-cycle pulse: a qualified record was lost (output busy)
// -----------------------------------------------------------------------------
module mac_grp_tx_time_stamp #(
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7,
    parameter int          MAX_PREAMBLE  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               tx_data,
    input  logic                     tx_en,
    input  logic [COUNTER_WIDTH-1:0] counter_val,
    output logic [31:0]              ts_time_hi,
    output logic [31:0]              ts_time_lo,
    output logic [3:0]               ts_msg_type,
    output logic [15:0]              ts_seq_id,
    output logic                     ts_valid,
    input  logic                     ts_ack,
    output logic                     ts_drop
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREAMBLE = 2'd1;
    localparam logic [1:0] HEADER   = 2'd2;
    localparam logic [1:0] WAIT_END = 2'd3;

    localparam logic [7:0] SFD     = 8'hD5;
    localparam logic [7:0] PRE_MAX = 8'(MAX_PREAMBLE);

    // Post-SFD byte indices of an untagged frame.
    localparam logic [5:0] IDX_ETH_HI = 6'd12;
    localparam logic [5:0] IDX_ETH_LO = 6'd13;
    localparam logic [5:0] IDX_MSG    = 6'd14;
    localparam logic [5:0] IDX_SEQ_HI = 6'd44;
    localparam logic [5:0] IDX_SEQ_LO = 6'd45;

    logic [1:0]               state;
    logic [7:0]               pre_cnt;
    logic [5:0]               hdr_idx;
    logic [COUNTER_WIDTH-1:0] cand_time;
    logic [3:0]               cand_msg;
    logic [15:0]              cand_seq;
    logic [7:0]               eth_hi;
    logic                     commit_p0;
    // Cleared by reset; a frame may only start once tx_en has been seen low,
    // so a reset in the middle of a frame never picks up its tail.
    logic                     line_idle_seen;

    logic                     is_sfd;
    logic [15:0]              eth_type;
    logic [5:0]               idx_off;
    logic                     vlan_tag_hit;
    logic                     at_eth_hi, at_eth_lo, at_msg, at_seq_hi, at_seq_lo;

    assign is_sfd   = (tx_data == SFD);
    assign eth_type = {eth_hi, tx_data};

`ifdef PTP_TX_VLAN_TAG_EN
    localparam logic [15:0] VLAN_TPID = 16'h8100;
    logic tagged;

    assign idx_off      = tagged ? 6'd4 : 6'd0;
    // Only one tag is skipped; a second 0x8100 falls into the non-PTP path.
    assign vlan_tag_hit = !tagged && (eth_type == VLAN_TPID);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tagged <= 1'b0;
        end else if (state != HEADER) begin
            tagged <= 1'b0;
        end else if (tx_en && at_eth_lo && vlan_tag_hit) begin
            tagged <= 1'b1;
        end
    end
`else
    assign idx_off      = 6'd0;
    assign vlan_tag_hit = 1'b0;
`endif

    assign at_eth_hi = (hdr_idx == IDX_ETH_HI + idx_off);
    assign at_eth_lo = (hdr_idx == IDX_ETH_LO + idx_off);
    assign at_msg    = (hdr_idx == IDX_MSG    + idx_off);
    assign at_seq_hi = (hdr_idx == IDX_SEQ_HI + idx_off);
    assign at_seq_lo = (hdr_idx == IDX_SEQ_LO + idx_off);

    // Frame parser: SFD search, header walk, candidate capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pre_cnt        <= '0;
            hdr_idx        <= '0;
            cand_time      <= '0;
            cand_msg       <= '0;
            cand_seq       <= '0;
            eth_hi         <= '0;
            commit_p0      <= 1'b0;
            line_idle_seen <= 1'b0;
        end else begin
            commit_p0 <= 1'b0;
            if (!tx_en) begin
                line_idle_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_en && line_idle_seen) begin
                        pre_cnt <= 8'd1;
                        if (is_sfd) begin
                            cand_time <= counter_val;
                            hdr_idx   <= '0;
                            state     <= HEADER;
                        end else begin
                            state <= (PRE_MAX <= 8'd1) ? WAIT_END : PREAMBLE;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!tx_en) begin
                        state <= IDLE;
                    end else if (is_sfd) begin
                        cand_time <= counter_val;
                        hdr_idx   <= '0;
                        state     <= HEADER;
                    end else if (pre_cnt + 8'd1 >= PRE_MAX) begin
                        pre_cnt <= PRE_MAX;
                        state   <= WAIT_END;
                    end else begin
                        pre_cnt <= pre_cnt + 8'd1;
                    end
                end
                HEADER: begin
                    if (!tx_en) begin
                        state <= IDLE;
                    end else begin
                        if (hdr_idx != IDX_SEQ_LO + idx_off) begin
                            hdr_idx <= hdr_idx + 6'd1;
                        end
                        if (at_eth_hi) begin
                            eth_hi <= tx_data;
                        end
                        if (at_eth_lo && (eth_type != PTP_ETHERTYPE) && !vlan_tag_hit) begin
                            state <= WAIT_END;
                        end
                        if (at_msg) begin
                            cand_msg <= tx_data[3:0];
                            // Only Sync/Delay_Req/Pdelay_Req/Pdelay_Resp are event messages.
                            if (tx_data[3:0] >= 4'd4) begin
                                state <= WAIT_END;
                            end
                        end
                        if (at_seq_hi) begin
                            cand_seq[15:8] <= tx_data;
                        end
                        if (at_seq_lo) begin
                            cand_seq[7:0] <= tx_data;
                            commit_p0     <= 1'b1;
                            state         <= WAIT_END;
                        end
                    end
                end
                WAIT_END: begin
                    if (!tx_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Record publication: commit one clock after the last sequenceId byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_time_hi  <= '0;
            ts_time_lo  <= '0;
            ts_msg_type <= '0;
            ts_seq_id   <= '0;
            ts_valid    <= 1'b0;
            ts_drop     <= 1'b0;
        end else begin
            ts_drop <= 1'b0;
            if (commit_p0) begin
                if (ts_valid && !ts_ack) begin
                    // Unconsumed record wins; the newcomer is reported lost.
                    ts_drop <= 1'b1;
                end else begin
                    ts_time_hi  <= cand_time[63:32];
                    ts_time_lo  <= cand_time[31:0];
                    ts_msg_type <= cand_msg;
                    ts_seq_id   <= cand_seq;
                    ts_valid    <= 1'b1;
                end
            end else if (ts_valid && ts_ack) begin
                ts_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_grp_tx_time_stamp.sv
`timescale 1ns/1ps
module tb_mac_grp_tx_time_stamp;
    localparam int MAXP = 8;
`ifdef PTP_TX_VLAN_TAG_EN
    localparam bit VLAN = 1'b1;
`else
    localparam bit VLAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_en = 1'b0;
    logic [63:0] counter_val = 64'h0;
    logic [31:0] ts_time_hi, ts_time_lo;
    logic [3:0]  ts_msg_type;
    logic [15:0] ts_seq_id;
    logic        ts_valid;
    logic        ts_ack = 1'b0;
    logic        ts_drop;

    mac_grp_tx_time_stamp #(
        .COUNTER_WIDTH(64),
        .PTP_ETHERTYPE(16'h88F7),
        .MAX_PREAMBLE (MAXP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .counter_val(counter_val),
        .ts_time_hi (ts_time_hi),
        .ts_time_lo (ts_time_lo),
        .ts_msg_type(ts_msg_type),
        .ts_seq_id  (ts_seq_id),
        .ts_valid   (ts_valid),
        .ts_ack     (ts_ack),
        .ts_drop    (ts_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cnt = 0, drop_cnt = 0;
    int last_rise_cyc = -1, last_drop_cyc = -1;
    logic prev_valid = 1'b0;
    int ack_cyc = -1;

    logic [7:0]  frame_q[$];
    logic [63:0] cv_q[$];
    int          cyc_q[$];

    // Reference view of the published record
    logic        m_valid = 1'b0;
    logic [63:0] m_time = 64'h0;
    logic [3:0]  m_msg = 4'h0;
    logic [15:0] m_seq = 16'h0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ts_valid && !prev_valid) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (ts_drop) begin
            drop_cnt++;
            last_drop_cyc = cyc;
        end
        prev_valid = ts_valid;
    endtask

    task automatic drive(input logic en, input logic [7:0] d);
        if (ack_cyc >= 0) ts_ack = (ack_cyc == cyc + 1);
        tx_en       = en;
        tx_data     = d;
        counter_val = counter_val + 64'd1;
        tick();
    endtask

    task automatic build_frame(input int npre, input logic [15:0] et, input logic [7:0] mbyte,
                               input logic [15:0] seq, input bit tag);
        int s, off;
        frame_q.delete();
        repeat (npre) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        s = frame_q.size();
        repeat (12) frame_q.push_back(8'($urandom));
        off = 0;
        if (tag) begin
            frame_q.push_back(8'h81);
            frame_q.push_back(8'h00);
            frame_q.push_back(8'($urandom));
            frame_q.push_back(8'($urandom));
            off = 4;
        end
        frame_q.push_back(et[15:8]);
        frame_q.push_back(et[7:0]);
        frame_q.push_back(mbyte);
        while (frame_q.size() - s < 44 + off) frame_q.push_back(8'($urandom));
        frame_q.push_back(seq[15:8]);
        frame_q.push_back(seq[7:0]);
        repeat ($urandom_range(2, 8)) frame_q.push_back(8'($urandom));
    endtask

    // Sends the first 'cut' bytes of frame_q (all if cut<0), then an idle gap.
    task automatic run_frame(input int cut);
        int n;
        cv_q.delete();
        cyc_q.delete();
        rise_cnt = 0; drop_cnt = 0; last_rise_cyc = -1; last_drop_cyc = -1;
        n = (cut >= 0 && cut < frame_q.size()) ? cut : frame_q.size();
        while (frame_q.size() > n) void'(frame_q.pop_back());
        for (int i = 0; i < n; i++) begin
            drive(1'b1, frame_q[i]);
            cv_q.push_back(counter_val);
            cyc_q.push_back(cyc);
        end
        repeat (4) drive(1'b0, 8'h00);
        ts_ack  = 1'b0;
        ack_cyc = -1;
    endtask

    // Parses the bytes actually sent, straight from the frame-format rules.
    function automatic bit ref_parse(output int sp, output logic [3:0] msg,
                                     output logic [15:0] seq, output int lat);
        int s, off;
        logic [15:0] et;
        sp = -1; msg = 4'h0; seq = 16'h0; lat = 0;
        for (int i = 0; i < frame_q.size() && i < MAXP; i++)
            if (sp < 0 && frame_q[i] == 8'hD5) sp = i;
        if (sp < 0) return 1'b0;
        s = sp + 1;
        off = 0;
        if (frame_q.size() < s + 14) return 1'b0;
        et = {frame_q[s+12], frame_q[s+13]};
        if (VLAN && et == 16'h8100) begin
            off = 4;
            if (frame_q.size() < s + 18) return 1'b0;
            et = {frame_q[s+16], frame_q[s+17]};
        end
        if (et != 16'h88F7) return 1'b0;
        if (frame_q.size() < s + 46 + off) return 1'b0;
        msg = frame_q[s+14+off][3:0];
        if (msg >= 4'd4) return 1'b0;
        seq = {frame_q[s+44+off], frame_q[s+45+off]};
        lat = 47 + off;
        return 1'b1;
    endfunction

    task automatic model_apply(input bit ack_at_commit, output int er, output int ed);
        int sp, lat, ec;
        logic [3:0] msg;
        logic [15:0] seq;
        bit q;
        q = ref_parse(sp, msg, seq, lat);
        er = -1; ed = -1;
        if (q) begin
            ec = cyc_q[sp] + lat;
            if (m_valid && !ack_at_commit) ed = ec;
            else begin
                if (!m_valid) er = ec;
                m_valid = 1'b1; m_time = cv_q[sp]; m_msg = msg; m_seq = seq;
            end
        end
    endtask

    task automatic do_ack();
        ts_ack = 1'b1;
        drive(1'b0, 8'h00);
        ts_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) drive(1'b0, 8'h00);
        checks++;
        if ({ts_valid, ts_drop, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== '0) begin
            errors++;
            $display("FAIL reset_asserted outputs got v=%0b d=%0b %h_%h m=%h s=%h want all 0",
                     ts_valid, ts_drop, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id);
        end
        reset_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00);
        checks++;
        if ({ts_valid, ts_drop, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== '0) begin
            errors++;
            $display("FAIL reset_released outputs got v=%0b d=%0b %h_%h want all 0",
                     ts_valid, ts_drop, ts_time_hi, ts_time_lo);
        end
    endtask

    task automatic test_ptp_basic();
        int er, ed;
        build_frame(7, 16'h88F7, 8'h00, 16'h1234, 1'b0);
        counter_val = 64'h0000_0001_0000_0010 - 64'd8;
        run_frame(-1);
        model_apply(1'b0, er, ed);
        checks++;
        if (last_rise_cyc - cyc_q[7] !== 47 || rise_cnt !== 1) begin
            errors++;
            $display("FAIL basic latency got=%0d rises=%0d want 47 and 1", last_rise_cyc - cyc_q[7], rise_cnt);
        end
        checks++;
        if (ts_valid !== 1'b1 || ts_time_hi !== 32'h1 || ts_time_lo !== 32'h10 ||
            ts_msg_type !== 4'h0 || ts_seq_id !== 16'h1234 || drop_cnt !== 0) begin
            errors++;
            $display("FAIL basic record got v=%0b %h_%h m=%h s=%h drops=%0d want 1 00000001_00000010 0 1234 0",
                     ts_valid, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id, drop_cnt);
        end
        do_ack();
        checks++;
        if (ts_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic ack got valid=%0b want 0", ts_valid);
        end
    endtask

    task automatic test_random_frames();
        int er, ed;
        logic [15:0] et;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0, 1: et = 16'h88F7;
                2: et = 16'h0800;
                default: et = 16'h8100;
            endcase
            build_frame($urandom_range(0, 7), et, 8'($urandom_range(0, 7)), 16'($urandom),
                        1'($urandom_range(0, 1)));
            counter_val = {$urandom, $urandom};
            run_frame(-1);
            model_apply(1'b0, er, ed);
            checks++;
            if (last_rise_cyc !== er || rise_cnt !== (er >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL random[%0d] rise got cyc=%0d n=%0d want cyc=%0d", k, last_rise_cyc, rise_cnt, er);
            end
            checks++;
            if (last_drop_cyc !== ed || drop_cnt !== (ed >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL random[%0d] drop got cyc=%0d n=%0d want cyc=%0d", k, last_drop_cyc, drop_cnt, ed);
            end
            checks++;
            if (ts_valid !== m_valid || {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
                errors++;
                $display("FAIL random[%0d] record got v=%0b %h_%h m=%h s=%h want v=%0b %h m=%h s=%h", k,
                         ts_valid, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id, m_valid, m_time, m_msg, m_seq);
            end
            if (m_valid && $urandom_range(0, 1) == 1) do_ack();
        end
        if (m_valid) do_ack();
    endtask

    task automatic test_non_event();
        int er, ed;
        ts_ack = 1'b1;
        drive(1'b0, 8'h00);
        ts_ack = 1'b0;
        checks++;
        if (ts_valid !== 1'b0 || ts_drop !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack got v=%0b d=%0b want 0 0", ts_valid, ts_drop);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) build_frame(7, 16'h88F7, 8'h08, 16'h5555, 1'b0);
            else        build_frame(7, 16'h0800, 8'h00, 16'h6666, 1'b0);
            run_frame(-1);
            model_apply(1'b0, er, ed);
            checks++;
            if (rise_cnt !== 0 || drop_cnt !== 0 || ts_valid !== 1'b0 || er !== -1) begin
                errors++;
                $display("FAIL non_event[%0d] got rises=%0d drops=%0d v=%0b want 0 0 0", k, rise_cnt, drop_cnt, ts_valid);
            end
        end
    endtask

    task automatic test_drop_and_ack();
        int er, ed;
        for (int k = 0; k < 2; k++) begin
            build_frame(7, 16'h88F7, 8'($urandom_range(0, 3)), 16'($urandom), 1'b0);
            run_frame(-1);
            model_apply(1'b0, er, ed);
            checks++;
            if (last_rise_cyc !== er || rise_cnt !== (er >= 0 ? 1 : 0) ||
                last_drop_cyc !== ed || drop_cnt !== (ed >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL drop[%0d] got rise=%0d/%0d drop=%0d/%0d want rise=%0d drop=%0d", k,
                         last_rise_cyc, rise_cnt, last_drop_cyc, drop_cnt, er, ed);
            end
            checks++;
            if (ts_valid !== m_valid || {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
                errors++;
                $display("FAIL drop[%0d] record got v=%0b %h_%h s=%h want v=%0b %h s=%h", k,
                         ts_valid, ts_time_hi, ts_time_lo, ts_seq_id, m_valid, m_time, m_seq);
            end
        end
        ts_ack = 1'b1;
        drive(1'b0, 8'h00);
        ts_ack = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (ts_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop ack got valid=%0b want 0", ts_valid);
        end
    endtask

    task automatic test_back_to_back();
        int er, ed;
        build_frame(7, 16'h88F7, 8'h01, 16'hA5A5, 1'b0);
        run_frame(-1);
        model_apply(1'b0, er, ed);
        build_frame(7, 16'h88F7, 8'h03, 16'h5A5A, 1'b0);
        ack_cyc = cyc + 8 + 47;
        run_frame(-1);
        model_apply(1'b1, er, ed);
        checks++;
        if (ts_valid !== 1'b1 || drop_cnt !== 0 || rise_cnt !== 0 ||
            {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
            errors++;
            $display("FAIL back_to_back got v=%0b drops=%0d rises=%0d %h_%h m=%h s=%h want 1 0 0 %h m=%h s=%h",
                     ts_valid, drop_cnt, rise_cnt, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id, m_time, m_msg, m_seq);
        end
        do_ack();
    endtask

    task automatic test_abort();
        int er, ed;
        for (int k = 0; k < 2; k++) begin
            build_frame(7, 16'h88F7, 8'h00, 16'($urandom), 1'b0);
            counter_val = {$urandom, $urandom};
            run_frame(k == 0 ? 8 + 30 : -1);
            model_apply(1'b0, er, ed);
            checks++;
            if (last_rise_cyc !== er || rise_cnt !== (er >= 0 ? 1 : 0) || drop_cnt !== 0 ||
                ts_valid !== m_valid || {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
                errors++;
                $display("FAIL abort[%0d] got rise=%0d v=%0b %h_%h s=%h want rise=%0d v=%0b %h s=%h", k,
                         last_rise_cyc, ts_valid, ts_time_hi, ts_time_lo, ts_seq_id, er, m_valid, m_time, m_seq);
            end
        end
        do_ack();
    endtask

    task automatic test_preamble_and_reset();
        int er, ed;
        build_frame(9, 16'h88F7, 8'h00, 16'h7777, 1'b0);
        run_frame(-1);
        model_apply(1'b0, er, ed);
        checks++;
        if (rise_cnt !== 0 || drop_cnt !== 0 || ts_valid !== 1'b0 || er !== -1) begin
            errors++;
            $display("FAIL long_preamble got rises=%0d drops=%0d v=%0b want 0 0 0", rise_cnt, drop_cnt, ts_valid);
        end
        // leave a record pending so the reset has something to clear
        build_frame(7, 16'h88F7, 8'h02, 16'h1357, 1'b0);
        run_frame(-1);
        model_apply(1'b0, er, ed);
        build_frame(7, 16'h88F7, 8'h00, 16'h2468, 1'b0);
        for (int i = 0; i < 8 + 20; i++) drive(1'b1, frame_q[i]);
        reset_n = 1'b0;
        #1;
        m_valid = 1'b0; m_time = 64'h0; m_msg = 4'h0; m_seq = 16'h0;
        checks++;
        if ({ts_valid, ts_drop, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs got v=%0b %h_%h m=%h s=%h want all 0",
                     ts_valid, ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id);
        end
        drive(1'b1, frame_q[28]);
        drive(1'b1, frame_q[29]);
        reset_n = 1'b1;
        for (int i = 30; i < frame_q.size(); i++) drive(1'b1, frame_q[i]);
        // a complete frame with no tx_en gap after reset must be ignored
        build_frame(7, 16'h88F7, 8'h00, 16'h3579, 1'b0);
        run_frame(-1);
        checks++;
        if (rise_cnt !== 0 || drop_cnt !== 0 || ts_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tail got rises=%0d drops=%0d v=%0b want 0 0 0", rise_cnt, drop_cnt, ts_valid);
        end
        build_frame(7, 16'h88F7, 8'h01, 16'($urandom), 1'b0);
        run_frame(-1);
        model_apply(1'b0, er, ed);
        checks++;
        if (last_rise_cyc !== er || rise_cnt !== 1 || ts_valid !== m_valid ||
            {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
            errors++;
            $display("FAIL clean_after_reset got rise=%0d v=%0b %h_%h s=%h want rise=%0d %h s=%h",
                     last_rise_cyc, ts_valid, ts_time_hi, ts_time_lo, ts_seq_id, er, m_time, m_seq);
        end
        do_ack();
    endtask

    task automatic test_vlan();
        int er, ed;
        build_frame(7, 16'h88F7, 8'h00, 16'hBEEF, 1'b1);
        counter_val = {$urandom, $urandom};
        run_frame(-1);
        model_apply(1'b0, er, ed);
        checks++;
        if (last_rise_cyc !== er || rise_cnt !== (er >= 0 ? 1 : 0) || drop_cnt !== 0) begin
            errors++;
            $display("FAIL vlan rise got cyc=%0d n=%0d drops=%0d want cyc=%0d", last_rise_cyc, rise_cnt, drop_cnt, er);
        end
        checks++;
        if (ts_valid !== m_valid || {ts_time_hi, ts_time_lo, ts_msg_type, ts_seq_id} !== {m_time, m_msg, m_seq}) begin
            errors++;
            $display("FAIL vlan record got v=%0b %h_%h s=%h want v=%0b %h s=%h",
                     ts_valid, ts_time_hi, ts_time_lo, ts_seq_id, m_valid, m_time, m_seq);
        end
        if (m_valid) do_ack();
    endtask

    initial begin
        test_reset();
        test_ptp_basic();
        test_random_frames();
        test_non_event();
        test_drop_and_ack();
        test_back_to_back();
        test_abort();
        test_preamble_and_reset();
        test_vlan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_grp_tx_time_stamp.md
Name: mac_grp_tx_time_stamp

Overview:
Egress counterpart of the MAC-group receive time stamper. Snoops the GMII-style transmit byte stream heading to the PHY and samples the free-running time counter on the SFD byte of every frame. If the frame turns out to be a PTP event message (EtherType 0x88F7, messageType < 4), it presents the timestamp with messageType and sequenceId on a valid/ack interface, so the PTP software path can match Sync/Delay_Req egress times.

Parameters:
COUNTER_WIDTH, 64, width of counter_val; must be 64. [63:32] maps to ts_time_hi and [31:0] to ts_time_lo.
PTP_ETHERTYPE, 16'h88F7, EtherType that qualifies a PTP frame.
MAX_PREAMBLE, 8, maximum bytes searched for SFD (0xD5) after tx_en rises, including the SFD.

Ports:
clk  in  1  single clock; all logic is rising-edge.
reset_n  in  1  asynchronous, active-low reset.
tx_data  in  8  transmit byte, sampled when tx_en=1.
tx_en  in  1  frame-active qualifier, high for the whole frame including preamble.
counter_val  in  COUNTER_WIDTH  free-running time counter.
ts_time_hi  out  32  captured counter_val[63:32].
ts_time_lo  out  32  captured counter_val[31:0].
ts_msg_type  out  4  PTP messageType nibble.
ts_seq_id  out  16  PTP sequenceId, big-endian as on the wire.
ts_valid  out  1  record available; held until accepted.
ts_ack  in  1  consumer accepts the record when ts_valid && ts_ack.
ts_drop  out  1  one-cycle pulse: a qualified record was lost because the output was still occupied.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM to IDLE; internal capture registers 0.
- FSM states: IDLE, PREAMBLE, HEADER, WAIT_END.
- IDLE:
  - On tx_en=1, go to PREAMBLE with pre_cnt=1.
  - If that first byte is 0xD5, treat it as SFD immediately (same rules as PREAMBLE).
- PREAMBLE:
  - On tx_data==0xD5 with tx_en=1: latch counter_val (the value present that cycle) into cand_time, clear byte index hdr_idx=0, go to HEADER.
  - Non-SFD byte: increment pre_cnt.
  - If pre_cnt reaches MAX_PREAMBLE without SFD: go to WAIT_END.
  - tx_en=0: go to IDLE.
- HEADER: hdr_idx counts post-SFD bytes from 0 (first destination MAC byte) and increments every tx_en=1 cycle.
  - Index 12/13: EtherType hi/lo.
  - Index 14: messageType = tx_data[3:0].
  - Index 44/45: sequenceId hi/lo.
  - At index 13: if EtherType != PTP_ETHERTYPE, go to WAIT_END.
  - At index 14: if messageType >= 4, go to WAIT_END.
  - At index 45: commit the candidate and go to WAIT_END.
- WAIT_END: stay until tx_en=0, then go to IDLE. A new frame needs at least one tx_en=0 cycle.
- tx_en falling in any state other than IDLE aborts the frame. A partial frame never commits.
- Commit:
  - Output registers load on the clock after the index-45 byte, and ts_valid=1 that same clock.
  - Latency from the SFD byte to ts_valid is 47 cycles.
- Handshake:
  - ts_valid falls the cycle after ts_valid && ts_ack.
  - ts_ack while ts_valid=0 is ignored.
  - Outputs stay stable while ts_valid=1 and not acked.
- Commit while ts_valid=1 and no ack that cycle: discard the new record, pulse ts_drop for 1 cycle, old record unchanged.
- Commit in the same cycle as ack: the new record replaces the old, ts_valid stays 1, no drop.
- Reset mid-frame: immediate return to IDLE; the rest of that frame is ignored until tx_en has been low.
- Counters saturate: pre_cnt at MAX_PREAMBLE, hdr_idx at 45. No wrap-around.

Optional Feature:
Macro PTP_TX_VLAN_TAG_EN.
- Defined: if the index-12/13 EtherType is 0x8100, skip the 4-byte tag. Take the EtherType from index 16/17, messageType from 18, sequenceId from 48/49, and commit after 49 (latency 51).
- Undefined: 0x8100 frames are treated as non-PTP.
- Untagged behaviour is identical in both builds.

Test Plan:
- Frame: 7x0x55, 0xD5, 12 MAC bytes, 0x88,0xF7, 0x00, payload with seq 0x1234 at idx 44/45; counter_val=0x00000001_00000010 on the SFD cycle -> ts_valid after 47 cycles; hi=0x1, lo=0x10, msg_type=0, seq_id=0x1234.
- Same frame with messageType 0x8 (Follow_Up), then EtherType 0x0800 -> no ts_valid, no ts_drop.
- Two qualified frames, ts_ack held 0 -> first record retained unchanged, single ts_drop pulse at the second commit; then ack -> ts_valid=0 next cycle.
- tx_en dropped at post-SFD index 30 of a PTP frame, then a valid frame -> only the second frame produces a record, with its own SFD timestamp.
- 9 preamble bytes without 0xD5 (MAX_PREAMBLE=8) -> no record; reset_n pulsed low mid-header -> all outputs 0 immediately; next clean frame records normally.
- (PTP_TX_VLAN_TAG_EN) 0x8100 tag + 0x88F7, seq 0xBEEF -> record after 51 cycles with seq_id=0xBEEF; macro undefined -> no record.
